// File: rtl/regf_mem_bridge_if.sv
// -----------------------------------------------------------------------------
// regf_mem_bridge_if
//
// Bundles the three channels around regf_mem_bridge: the valid/ready request
// channel, the valid/ready response channel and the single-cycle strobe
// channel to the register file.
// Signal suffixes (_i/_o) are named from the bridge's point of view.
//
// Modports:
//   slave  - the bridge itself (takes requests, drives the regf strobe)
//   master - the environment (requester, response consumer, regf instance)
//
// Parameters:
//   AWIDTH - word address width
//   DWIDTH - data width
// -----------------------------------------------------------------------------
interface regf_mem_bridge_if #(
  parameter int AWIDTH = 13,
  parameter int DWIDTH = 32
);

  // Request channel
  logic              req_valid_i;
  logic              req_ready_o;
  logic [AWIDTH-1:0] req_addr_i;
  logic              req_write_i;
  logic [DWIDTH-1:0] req_wdata_i;

  // Response channel
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DWIDTH-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  // Register-file strobe channel
  logic              mem_ena_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic              mem_wena_o;
  logic [DWIDTH-1:0] mem_wdata_o;
  logic [DWIDTH-1:0] mem_rdata_i;
  logic              mem_err_i;

  modport slave (
    input  req_valid_i,
    output req_ready_o,
    input  req_addr_i,
    input  req_write_i,
    input  req_wdata_i,
    output rsp_valid_o,
    input  rsp_ready_i,
    output rsp_rdata_o,
    output rsp_err_o,
    output mem_ena_o,
    output mem_addr_o,
    output mem_wena_o,
    output mem_wdata_o,
    input  mem_rdata_i,
    input  mem_err_i
  );

  modport master (
    output req_valid_i,
    input  req_ready_o,
    output req_addr_i,
    output req_write_i,
    output req_wdata_i,
    input  rsp_valid_o,
    output rsp_ready_i,
    input  rsp_rdata_o,
    input  rsp_err_o,
    input  mem_ena_o,
    input  mem_addr_o,
    input  mem_wena_o,
    input  mem_wdata_o,
    output mem_rdata_i,
    output mem_err_i
  );

endinterface

// File: rtl/regf_mem_bridge.sv
// -----------------------------------------------------------------------------
// regf_mem_bridge
//
// Front-end for the mem_* port of a generated register file. It takes a
// valid/ready request and turns it into the regf single-cycle strobe. It then
// returns the result on a valid/ready response channel. Only one transaction
// is in flight at a time. The requester is back-pressured until the
// response has been consumed.
//
// Transaction flow: IDLE --accept--> ACCESS (one strobe cycle) --> RESP.
// A response handshake in RESP may accept the next request in the same
// cycle. This gives one transaction every two cycles.
//
// Ports:
//   main_clk_i    - clock
//   main_rst_an_i - asynchronous reset, active low
//   soft_rst_i    - synchronous flush, active high; drops the transaction in flight
//   busy_o        - high whenever a transaction is held (state not IDLE)
//   bus           - regf_mem_bridge_if.slave: request, response and regf strobe
//
// Parameters:
//   AWIDTH     - word address width (matches regf mem_addr_i)
//   DWIDTH     - data width (matches regf mem_wdata_i/mem_rdata_o)
//   ADDR_LIMIT - number of valid word addresses (address check only)
//
// Optional feature (compile-time macro REGF_MEM_BRIDGE_ADDR_CHECK_EN):
//   When defined, a held address >= ADDR_LIMIT is not forwarded to the
//   regf. No strobe is issued for it. The response returns err=1 and
//   rdata=0 with unchanged latency. When undefined, every address is
//   forwarded and no comparator exists.
// -----------------------------------------------------------------------------
module regf_mem_bridge #(
  parameter int AWIDTH     = 13,
  parameter int DWIDTH     = 32,
  parameter int ADDR_LIMIT = 2**AWIDTH
) (
  input  logic             main_clk_i,
  input  logic             main_rst_an_i,
  input  logic             soft_rst_i,
  output logic             busy_o,
  regf_mem_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e            state_q,     state_d;
  logic [AWIDTH-1:0] addr_q,      addr_d;
  logic              write_q,     write_d;
  logic [DWIDTH-1:0] wdata_q,     wdata_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;

  logic              req_ready_s;
  logic              req_fire_s;
  logic              addr_bad_s;
  logic              access_s;
  logic              cap_err_s;
  logic [DWIDTH-1:0] cap_rdata_s;

`ifdef REGF_MEM_BRIDGE_ADDR_CHECK_EN
  // One extra bit so that the default limit of 2**AWIDTH is representable.
  localparam logic [AWIDTH:0] ADDR_LIMIT_W = (AWIDTH+1)'(ADDR_LIMIT);

  assign addr_bad_s = ({1'b0, addr_q} >= ADDR_LIMIT_W);
`else
  // The limit is only meaningful with the address check built in.
  logic unused_addr_limit_s;

  assign unused_addr_limit_s = (ADDR_LIMIT > 32'sd0);
  assign addr_bad_s          = 1'b0;
`endif

  // A request may be taken when nothing is held, or when the held response
  // is being consumed in this very cycle. A flush blocks acceptance.
  assign req_ready_s = ~soft_rst_i &
                       ((state_q == ST_IDLE) |
                        ((state_q == ST_RESP) & bus.rsp_ready_i));
  assign req_fire_s  = req_ready_s & bus.req_valid_i;

  // The strobe is gated combinationally by a flush and by a rejected address.
  // An async reset forces state_q to IDLE, so no strobe is glitched out.
  assign access_s = (state_q == ST_ACCESS) & ~soft_rst_i & ~addr_bad_s;

  // Values sampled from the regf in the strobe cycle. Writes and errors
  // return zero data.
  assign cap_err_s   = bus.mem_err_i | addr_bad_s;
  assign cap_rdata_s = (write_q | cap_err_s) ? {DWIDTH{1'b0}} : bus.mem_rdata_i;

  // Next-state, holding-register and response-register logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (soft_rst_i) begin
      state_d     = ST_IDLE;
      addr_d      = {AWIDTH{1'b0}};
      write_d     = 1'b0;
      wdata_d     = {DWIDTH{1'b0}};
      rsp_rdata_d = {DWIDTH{1'b0}};
      rsp_err_d   = 1'b0;
    end else begin
      if (req_fire_s) begin
        addr_d  = bus.req_addr_i;
        write_d = bus.req_write_i;
        wdata_d = bus.req_wdata_i;
      end else begin
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (req_fire_s) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_ACCESS: begin
          rsp_err_d   = cap_err_s;
          rsp_rdata_d = cap_rdata_s;
          state_d     = ST_RESP;
        end

        ST_RESP: begin
          // The response stays valid and stable until it is consumed.
          if (bus.rsp_ready_i) begin
            if (req_fire_s) begin
              state_d = ST_ACCESS;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_RESP;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, holding and response registers
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= {AWIDTH{1'b0}};
      write_q     <= 1'b0;
      wdata_q     <= {DWIDTH{1'b0}};
      rsp_rdata_q <= {DWIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready_o = req_ready_s;
  assign bus.rsp_valid_o = (state_q == ST_RESP);
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;

  // Every strobe-channel output is zero outside an active strobe cycle.
  assign bus.mem_ena_o   = access_s;
  assign bus.mem_wena_o  = access_s & write_q;
  assign bus.mem_addr_o  = access_s ? addr_q  : {AWIDTH{1'b0}};
  assign bus.mem_wdata_o = access_s ? wdata_q : {DWIDTH{1'b0}};

  assign busy_o = (state_q != ST_IDLE);

endmodule
